// File: rtl/lsu_dbus_ctrl_if.sv
// Core-side memory-control and data-bus signals of the load/store unit.
// master = LSU view, slave = core/bus-fabric view.
interface lsu_dbus_ctrl_if #(
    parameter int XLEN = 32
);
    // decoder / datapath side
    logic             mem_read_en_i;
    logic             mem_write_en_i;
    logic [1:0]       mem_size_i;
    logic             mem_sign_ext_i;
    logic [XLEN-1:0]  addr_i;
    logic [XLEN-1:0]  store_data_i;
    logic             stall_o;
    logic [XLEN-1:0]  load_data_o;
    logic             load_valid_o;
    logic             misaligned_o;

    // data bus side
    logic             dbus_req_o;
    logic             dbus_we_o;
    logic [XLEN-1:0]  dbus_addr_o;
    logic [3:0]       dbus_be_o;
    logic [XLEN-1:0]  dbus_wdata_o;
    logic             dbus_gnt_i;
    logic             dbus_rvalid_i;
    logic [XLEN-1:0]  dbus_rdata_i;

    modport master (
        input  mem_read_en_i, mem_write_en_i, mem_size_i, mem_sign_ext_i,
        input  addr_i, store_data_i,
        input  dbus_gnt_i, dbus_rvalid_i, dbus_rdata_i,
        output stall_o, load_data_o, load_valid_o, misaligned_o,
        output dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o
    );

    modport slave (
        output mem_read_en_i, mem_write_en_i, mem_size_i, mem_sign_ext_i,
        output addr_i, store_data_i,
        output dbus_gnt_i, dbus_rvalid_i, dbus_rdata_i,
        input  stall_o, load_data_o, load_valid_o, misaligned_o,
        input  dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o
    );
endinterface

// File: rtl/lsu_dbus_ctrl.sv
// Load/store unit: one access per instruction on a req/gnt/rvalid bus; LSU_MISALIGN_TRAP_EN enables misaligned trapping.
// Latency 4 cycles accept->DONE (+1 per gnt or rvalid wait cycle); core is held on stall_o until DONE.
module lsu_dbus_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    lsu_dbus_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [XLEN-1:0]   r_addr;
    logic [1:0]        r_size;
    logic              r_sext;
    logic [XLEN-1:0]   r_sd;
    logic              r_we;
    logic              r_misal;
    logic [XLEN-1:0]   r_load_data;

    logic              w_accept;
    logic              w_misal_in;
    logic [1:0]        w_off;
    logic [3:0]        w_be;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_shifted;
    logic [XLEN-1:0]   w_load_fmt;
    logic              w_rsp;

    assign w_accept = (r_state == ST_IDLE) && (bus.mem_read_en_i || bus.mem_write_en_i);
    assign w_rsp    = (r_state == ST_WAIT) && bus.dbus_rvalid_i;

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misal_in = ((bus.mem_size_i == SZ_HALF) && bus.addr_i[0]) ||
                        (bus.mem_size_i[1] && (bus.addr_i[1:0] != 2'b00));
`else
    assign w_misal_in = 1'b0;
`endif

    // Lane offset ignores low address bits a size cannot use, so the
    // non-trapping build simply rounds a misaligned access down.
    always_comb begin
        w_off = 2'b00;
        case (r_size)
            SZ_BYTE: w_off = r_addr[1:0];
            SZ_HALF: w_off = {r_addr[1], 1'b0};
            default: w_off = 2'b00;
        endcase
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_sd;
        case (r_size)
            SZ_BYTE: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{r_sd[7:0]}};
            end
            SZ_HALF: begin
                w_be    = 4'b0011 << w_off;
                w_wdata = {2{r_sd[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = r_sd;
            end
        endcase
    end

    assign w_shifted = bus.dbus_rdata_i >> {w_off, 3'b000};

    always_comb begin
        w_load_fmt = w_shifted;
        case (r_size)
            SZ_BYTE: w_load_fmt = {{(XLEN-8){w_shifted[7] & r_sext}}, w_shifted[7:0]};
            SZ_HALF: w_load_fmt = {{(XLEN-16){w_shifted[15] & r_sext}}, w_shifted[15:0]};
            default: w_load_fmt = w_shifted;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_size      <= 2'b00;
            r_sext      <= 1'b0;
            r_sd        <= '0;
            r_we        <= 1'b0;
            r_misal     <= 1'b0;
            r_load_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr  <= bus.addr_i;
                r_size  <= bus.mem_size_i;
                r_sext  <= bus.mem_sign_ext_i;
                r_sd    <= bus.store_data_i;
                r_we    <= bus.mem_write_en_i;
                r_misal <= w_misal_in;
                if (w_misal_in) begin
                    r_load_data <= '0;
                end
            end
            if (w_rsp && !r_we) begin
                r_load_data <= w_load_fmt;
            end
        end
    end

    assign bus.load_data_o = r_load_data;

    always_comb begin
        w_state_nxt      = r_state;
        bus.stall_o      = 1'b0;
        bus.load_valid_o = 1'b0;
        bus.misaligned_o = 1'b0;
        bus.dbus_req_o   = 1'b0;
        bus.dbus_we_o    = 1'b0;
        bus.dbus_addr_o  = '0;
        bus.dbus_be_o    = 4'b0000;
        bus.dbus_wdata_o = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    bus.stall_o = 1'b1;
                    w_state_nxt = w_misal_in ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                bus.stall_o      = 1'b1;
                bus.dbus_req_o   = 1'b1;
                bus.dbus_we_o    = r_we;
                bus.dbus_addr_o  = {r_addr[XLEN-1:2], 2'b00};
                bus.dbus_be_o    = w_be;
                bus.dbus_wdata_o = w_wdata;
                if (bus.dbus_gnt_i) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                bus.stall_o = 1'b1;
                if (bus.dbus_rvalid_i) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.load_valid_o = !r_we && !r_misal;
`ifdef LSU_MISALIGN_TRAP_EN
                bus.misaligned_o = r_misal;
`endif
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_dbus_ctrl.sv
// Bench for lsu_dbus_ctrl: directed vector table, reset/misalign sequences, and random accesses vs. a lane model.
module tb_lsu_dbus_ctrl;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    lsu_dbus_ctrl_if #(.XLEN(32)) bus();

    lsu_dbus_ctrl #(.XLEN(32)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] last_ld = 32'h0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] ad;
        logic [31:0] sd;
        logic [31:0] rdat;
        int          gd;
        int          rvd;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [31:0] e_ld;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.mem_read_en_i  = 1'b0;
        bus.mem_write_en_i = 1'b0;
        bus.mem_size_i     = 2'b00;
        bus.mem_sign_ext_i = 1'b0;
        bus.addr_i         = 32'h0;
        bus.store_data_i   = 32'h0;
        bus.dbus_gnt_i     = 1'b0;
        bus.dbus_rvalid_i  = 1'b0;
        bus.dbus_rdata_i   = 32'h0;
    endtask

    // Reference lane arithmetic, derived from byte offsets rather than masks/shifts of the RTL.
    function automatic logic [1:0] m_off(input logic [1:0] sz, input logic [31:0] ad);
        int a;
        a = int'(ad % 4);
        if (sz == 2'd0) return 2'(a);
        if (sz == 2'd1) return (a >= 2) ? 2'd2 : 2'd0;
        return 2'd0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] ad);
        int o;
        o = int'(m_off(sz, ad));
        if (sz == 2'd0) return 4'(1 << o);
        if (sz == 2'd1) return 4'(3 << o);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] sd);
        if (sz == 2'd0) return (sd % 256) * 32'h01010101;
        if (sz == 2'd1) return (sd % 65536) * 32'h00010001;
        return sd;
    endfunction

    function automatic logic [31:0] m_ld(input logic [1:0] sz, input logic sx,
                                         input logic [31:0] ad, input logic [31:0] rdat);
        logic [31:0] v;
        v = rdat >> (8 * int'(m_off(sz, ad)));
        if (sz == 2'd0) begin
            v = v % 256;
            if (sx && v >= 128) v = v + 32'hFFFFFF00;
            return v;
        end
        if (sz == 2'd1) begin
            v = v % 65536;
            if (sx && v >= 32768) v = v + 32'hFFFF0000;
            return v;
        end
        return rdat;
    endfunction

    function automatic logic m_misal(input logic [1:0] sz, input logic [31:0] ad);
        if (sz == 2'd1) return (ad % 2) != 0;
        if (sz >= 2'd2) return (ad % 4) != 0;
        return 1'b0;
    endfunction

    task automatic run_access(input string nm, input logic rd, input logic wr,
                              input logic [1:0] sz, input logic sx,
                              input logic [31:0] ad, input logic [31:0] sd, input logic [31:0] rdat,
                              input int gd, input int rvd,
                              input logic [31:0] e_addr, input logic [3:0] e_be,
                              input logic [31:0] e_wd, input logic [31:0] e_ld);
        @(negedge clk_i);
        bus.mem_read_en_i  = rd;
        bus.mem_write_en_i = wr;
        bus.mem_size_i     = sz;
        bus.mem_sign_ext_i = sx;
        bus.addr_i         = ad;
        bus.store_data_i   = sd;
        bus.dbus_gnt_i     = 1'b0;
        bus.dbus_rvalid_i  = 1'b0;
        #1;
        chk({nm, " accept stall"}, 32'(bus.stall_o), 32'd1);
        chk({nm, " accept req"}, 32'(bus.dbus_req_o), 32'd0);
        for (int k = 0; k <= gd; k++) begin
            @(negedge clk_i);
            bus.dbus_gnt_i    = (k == gd);
            bus.dbus_rvalid_i = 1'($urandom_range(0, 1));
            bus.dbus_rdata_i  = $urandom;
            #1;
            chk({nm, " req"}, 32'(bus.dbus_req_o), 32'd1);
            chk({nm, " req stall"}, 32'(bus.stall_o), 32'd1);
            chk({nm, " addr"}, bus.dbus_addr_o, e_addr);
            chk({nm, " be"}, 32'(bus.dbus_be_o), 32'(e_be));
            chk({nm, " we"}, 32'(bus.dbus_we_o), 32'(wr));
            if (wr) chk({nm, " wdata"}, bus.dbus_wdata_o, e_wd);
        end
        for (int k = 0; k <= rvd; k++) begin
            @(negedge clk_i);
            bus.dbus_gnt_i    = 1'b0;
            bus.dbus_rvalid_i = (k == rvd);
            bus.dbus_rdata_i  = (k == rvd) ? rdat : $urandom;
            #1;
            chk({nm, " wait req"}, 32'(bus.dbus_req_o), 32'd0);
            chk({nm, " wait stall"}, 32'(bus.stall_o), 32'd1);
            chk({nm, " wait lvalid"}, 32'(bus.load_valid_o), 32'd0);
        end
        @(negedge clk_i);
        bus.dbus_rvalid_i = 1'b0;
        bus.dbus_rdata_i  = $urandom;
        #1;
        chk({nm, " done stall"}, 32'(bus.stall_o), 32'd0);
        chk({nm, " done lvalid"}, 32'(bus.load_valid_o), 32'(!wr));
        chk({nm, " done misal"}, 32'(bus.misaligned_o), 32'd0);
        if (!wr) begin
            chk({nm, " load data"}, bus.load_data_o, e_ld);
            last_ld = e_ld;
        end
        @(negedge clk_i);
        drive_idle();
        #1;
        chk({nm, " after lvalid"}, 32'(bus.load_valid_o), 32'd0);
        chk({nm, " after stall"}, 32'(bus.stall_o), 32'd0);
        chk({nm, " after req"}, 32'(bus.dbus_req_o), 32'd0);
        chk({nm, " held data"}, bus.load_data_o, last_ld);
    endtask

`ifdef LSU_MISALIGN_TRAP_EN
    task automatic run_misal(input string nm, input logic rd, input logic wr,
                             input logic [1:0] sz, input logic [31:0] ad);
        @(negedge clk_i);
        bus.mem_read_en_i  = rd;
        bus.mem_write_en_i = wr;
        bus.mem_size_i     = sz;
        bus.addr_i         = ad;
        #1;
        chk({nm, " accept stall"}, 32'(bus.stall_o), 32'd1);
        chk({nm, " accept req"}, 32'(bus.dbus_req_o), 32'd0);
        @(negedge clk_i);
        #1;
        chk({nm, " done req"}, 32'(bus.dbus_req_o), 32'd0);
        chk({nm, " done stall"}, 32'(bus.stall_o), 32'd0);
        chk({nm, " misal"}, 32'(bus.misaligned_o), 32'd1);
        chk({nm, " lvalid"}, 32'(bus.load_valid_o), 32'd0);
        chk({nm, " data zero"}, bus.load_data_o, 32'h0);
        last_ld = 32'h0;
        @(negedge clk_i);
        drive_idle();
        #1;
        chk({nm, " misal once"}, 32'(bus.misaligned_o), 32'd0);
        chk({nm, " req idle"}, 32'(bus.dbus_req_o), 32'd0);
    endtask
`endif

    initial begin
        logic        rd, wr, sx;
        logic [1:0]  sz;
        logic [31:0] ad, sd, rdat;
        int          gd, rvd;

        tbl[0] = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h203, 32'h000000A5, 32'h0, 0, 0, 32'h200, 4'h8, 32'hA5A5A5A5, 32'h0};
        tbl[2] = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FF7F01, 0, 0, 32'h100, 4'h8, 32'h0, 32'hFFFFFF80};
        tbl[3] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FF7F01, 0, 0, 32'h100, 4'h8, 32'h0, 32'h00000080};
        tbl[4] = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h8001FFFF, 3, 0, 32'h100, 4'hC, 32'h0, 32'hFFFF8001};
        tbl[5] = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h8001FFFF, 3, 0, 32'h100, 4'hC, 32'h0, 32'h00008001};
        tbl[6] = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h342, 32'hCAFE1234, 32'h0, 1, 2, 32'h340, 4'hC, 32'h12341234, 32'h0};
        tbl[7] = '{1'b1, 1'b1, 2'd3, 1'b0, 32'h10C, 32'h11223344, 32'h0, 0, 1, 32'h10C, 4'hF, 32'h11223344, 32'h0};
        tbl[8] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h101, 32'h0, 32'h0000AB00, 2, 1, 32'h100, 4'h2, 32'h0, 32'h000000AB};

        drive_idle();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst stall", 32'(bus.stall_o), 32'd0);
        chk("rst req", 32'(bus.dbus_req_o), 32'd0);
        chk("rst we", 32'(bus.dbus_we_o), 32'd0);
        chk("rst addr", bus.dbus_addr_o, 32'h0);
        chk("rst be", 32'(bus.dbus_be_o), 32'd0);
        chk("rst wdata", bus.dbus_wdata_o, 32'h0);
        chk("rst lvalid", 32'(bus.load_valid_o), 32'd0);
        chk("rst ldata", bus.load_data_o, 32'h0);
        chk("rst misal", 32'(bus.misaligned_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_access($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].sz, tbl[i].sx,
                       tbl[i].ad, tbl[i].sd, tbl[i].rdat, tbl[i].gd, tbl[i].rvd,
                       tbl[i].e_addr, tbl[i].e_be, tbl[i].e_wd, tbl[i].e_ld);
        end

        // reset pulse while a load waits for its response; the late rvalid must be dropped
        @(negedge clk_i);
        bus.mem_read_en_i = 1'b1;
        bus.mem_size_i    = 2'd2;
        bus.addr_i        = 32'h100;
        #1;
        chk("rstmid accept stall", 32'(bus.stall_o), 32'd1);
        @(negedge clk_i);
        bus.dbus_gnt_i = 1'b1;
        #1;
        chk("rstmid req", 32'(bus.dbus_req_o), 32'd1);
        @(negedge clk_i);
        bus.dbus_gnt_i = 1'b0;
        #1;
        chk("rstmid wait stall", 32'(bus.stall_o), 32'd1);
        @(negedge clk_i);
        drive_idle();
        rst_ni = 1'b0;
        #1;
        last_ld = 32'h0;
        chk("rstmid stall", 32'(bus.stall_o), 32'd0);
        chk("rstmid req0", 32'(bus.dbus_req_o), 32'd0);
        chk("rstmid ldata", bus.load_data_o, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        bus.dbus_rvalid_i = 1'b1;
        bus.dbus_rdata_i  = 32'hDEADBEEF;
        #1;
        chk("rstmid late lvalid", 32'(bus.load_valid_o), 32'd0);
        @(negedge clk_i);
        bus.dbus_rvalid_i = 1'b0;
        #1;
        chk("rstmid after lvalid", 32'(bus.load_valid_o), 32'd0);
        chk("rstmid after stall", 32'(bus.stall_o), 32'd0);
        chk("rstmid after ldata", bus.load_data_o, 32'h0);

`ifdef LSU_MISALIGN_TRAP_EN
        run_misal("lw101", 1'b1, 1'b0, 2'd2, 32'h101);
`else
        run_access("lw101", 1'b1, 1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h55AA00FF, 0, 0,
                   32'h100, 4'hF, 32'h0, 32'h55AA00FF);
`endif

        for (int i = 0; i < 40; i++) begin
            wr   = 1'($urandom_range(0, 1));
            rd   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            sz   = 2'($urandom_range(0, 3));
            sx   = 1'($urandom_range(0, 1));
            ad   = $urandom;
            sd   = $urandom;
            rdat = $urandom;
            gd   = $urandom_range(0, 3);
            rvd  = $urandom_range(0, 3);
`ifdef LSU_MISALIGN_TRAP_EN
            if (m_misal(sz, ad)) begin
                run_misal($sformatf("rnd%0d", i), rd, wr, sz, ad);
                continue;
            end
`endif
            run_access($sformatf("rnd%0d", i), rd, wr, sz, sx, ad, sd, rdat, gd, rvd,
                       {ad[31:2], 2'b00}, m_be(sz, ad), m_wd(sz, sd), m_ld(sz, sx, ad, rdat));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
